// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display path: mode encoding,
// display FSM states, seven-segment patterns and the BCD add-3 helper.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b100,
    RUNNING = 3'b001,
    CLEAR   = 3'b010
  } state_t;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } disp_state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Bit order {dp,g,f,e,d,c,b,a}; dp is never lit.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  function automatic logic [7:0] bcd_adjust(input logic [7:0] bcd);
    logic [7:0] r;
    r[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    r[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes go blank.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    for (int d = 0; d < 10; d++) begin
      if (bcd_i == 4'(d)) seg_o = SEG_DIGIT[d];
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch display: serial binary-to-BCD conversion, two-digit seven-segment
// output and registered mode LEDs. Optional IDLE blinking with STOPWATCH_DISPLAY_BLINK_EN.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int TIME_W     = 5,
  parameter int BLINK_HALF = 50
) (
  input  logic              clk,
  input  logic              nRst_i,
  input  logic [2:0]        mode_i,
  input  logic [TIME_W-1:0] time_i,
  output logic [7:0]        ss1_o,
  output logic [7:0]        ss0_o,
  output logic              red_o,
  output logic              green_o,
  output logic              blue_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(TIME_W + 1);

  if (TIME_W > 6 || TIME_W < 1 || BLINK_HALF < 2) begin : g_param_check
    $error("stopwatch_display: TIME_W must be 1..6 and BLINK_HALF at least 2");
  end

  disp_state_t       state_q, state_d;
  logic [TIME_W-1:0] shreg_q, shreg_d;
  logic [TIME_W-1:0] last_q, last_d;
  logic [7:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic [7:0]        seg1_q, seg1_d;
  logic [7:0]        seg0_q, seg0_d;
  logic [7:0]        tens_seg, ones_seg;
  logic              red_q, green_q, blue_q, bad_q;
  logic              blink_blank;

  seg7_decode u_tens (.bcd_i(bcd_q[7:4]), .seg_o(tens_seg));
  seg7_decode u_ones (.bcd_i(bcd_q[3:0]), .seg_o(ones_seg));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    seg1_d  = seg1_q;
    seg0_d  = seg0_q;
    case (state_q)
      S_WAIT: begin
        if (time_i != last_q || pend_q) begin
          shreg_d = time_i;
          last_d  = time_i;
          bcd_d   = 8'h00;
          cnt_d   = '0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adjust(bcd_q), shreg_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(TIME_W - 1)) state_d = S_DONE;
        if (time_i != last_q) pend_d = 1'b1;
      end
      S_DONE: begin
        // Both digits update on the same edge so no half-converted value is shown.
        seg1_d  = (bcd_q[7:4] == 4'd0) ? SEG_BLANK : tens_seg;
        seg0_d  = ones_seg;
        busy_d  = 1'b0;
        state_d = S_WAIT;
        if (time_i != last_q) pend_d = 1'b1;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      state_q <= S_WAIT;
      shreg_q <= '0;
      last_q  <= '0;
      bcd_q   <= 8'h00;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      seg1_q  <= SEG_BLANK;
      seg0_q  <= SEG_DIGIT[0];
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      seg1_q  <= seg1_d;
      seg0_q  <= seg0_d;
    end
  end

  // Unknown mode encodings darken everything while the conversion keeps running.
  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      red_q   <= 1'b0;
      green_q <= 1'b0;
      blue_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      red_q   <= (mode_i == CLEAR);
      green_q <= (mode_i == RUNNING);
      blue_q  <= (mode_i == IDLE);
      bad_q   <= !(mode_i == CLEAR || mode_i == RUNNING || mode_i == IDLE);
    end
  end

`ifdef STOPWATCH_DISPLAY_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_HALF);

  logic [BLINK_W-1:0] blink_q;
  logic               vis_q;

  always_ff @(posedge clk) begin
    if (!nRst_i || !blue_q) begin
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else if (blink_q == BLINK_W'(BLINK_HALF - 1)) begin
      blink_q <= '0;
      vis_q   <= ~vis_q;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  // Gated by blue_q so the digits reappear on the very edge IDLE is left.
  assign blink_blank = blue_q & ~vis_q;
`else
  assign blink_blank = 1'b0;
`endif

  assign ss1_o   = (bad_q || blink_blank) ? SEG_BLANK : seg1_q;
  assign ss0_o   = (bad_q || blink_blank) ? SEG_BLANK : seg0_q;
  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: directed vector table, corner-case
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_stopwatch_display;

  localparam int TIME_W     = 5;
  localparam int BLINK_HALF = 50;
  localparam logic [2:0] M_RUN   = 3'b001;
  localparam logic [2:0] M_CLEAR = 3'b010;
  localparam logic [2:0] M_IDLE  = 3'b100;

  logic              clk = 1'b0;
  logic              nRst_i;
  logic [2:0]        mode_i;
  logic [TIME_W-1:0] time_i;
  logic [7:0]        ss1_o, ss0_o;
  logic              red_o, green_o, blue_o, busy_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] segTab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Model: a conversion occupies a busy window of TIME_W+2 edges after capture.
  int mRemain = 0, mCapt = 0, mLast = 0, mShown = 0, mIdleRun = 0;
  bit mPend = 0, mR = 0, mG = 0, mB = 0, mBad = 0;

  stopwatch_display #(.TIME_W(TIME_W), .BLINK_HALF(BLINK_HALF)) dut (
    .clk(clk), .nRst_i(nRst_i), .mode_i(mode_i), .time_i(time_i),
    .ss1_o(ss1_o), .ss0_o(ss0_o), .red_o(red_o), .green_o(green_o),
    .blue_o(blue_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic modelEdge();
    int t;
    t = int'(time_i);
    if (!nRst_i) begin
      mRemain = 0; mLast = 0; mPend = 0; mShown = 0; mIdleRun = 0;
      mR = 0; mG = 0; mB = 0; mBad = 0;
      return;
    end
    if (mB) mIdleRun++; else mIdleRun = 0;
    if (mRemain == 0) begin
      if (t != mLast || mPend) begin
        mCapt = t; mLast = t; mPend = 0; mRemain = TIME_W + 1;
      end
    end else begin
      if (t != mLast) mPend = 1;
      mRemain--;
      if (mRemain == 0) mShown = mCapt;
    end
    mR   = (mode_i == M_CLEAR);
    mG   = (mode_i == M_RUN);
    mB   = (mode_i == M_IDLE);
    mBad = !(mR || mG || mB);
  endtask

  task automatic applyStimulus(input logic [2:0] m, input int t, input logic nrst);
    mode_i = m;
    time_i = TIME_W'(t);
    nRst_i = nrst;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] e1, input logic [7:0] e0,
                             input logic [2:0] eLed, input logic eBusy);
    checks++;
    if (ss1_o !== e1 || ss0_o !== e0 || {red_o, green_o, blue_o} !== eLed || busy_o !== eBusy) begin
      failures++;
      $display("[TB] FAIL %s: got ss1=%h ss0=%h rgb=%b busy=%b, expected ss1=%h ss0=%h rgb=%b busy=%b",
               name, ss1_o, ss0_o, {red_o, green_o, blue_o}, busy_o, e1, e0, eLed, eBusy);
    end
  endtask

  task automatic checkModel(input string name);
    bit blank;
    logic [7:0] e1, e0;
    blank = mBad;
`ifdef STOPWATCH_DISPLAY_BLINK_EN
    if (mB && ((mIdleRun / BLINK_HALF) % 2 == 1)) blank = 1;
`endif
    e1 = (mShown / 10 == 0) ? 8'h00 : segTab[mShown / 10];
    e0 = segTab[mShown % 10];
    if (blank) begin e1 = 8'h00; e0 = 8'h00; end
    checkOutput(name, e1, e0, {mR, mG, mB}, mRemain != 0);
  endtask

  typedef struct {
    logic [2:0] mode;
    int         t;
    int         cycles;
    logic [7:0] ss1;
    logic [7:0] ss0;
    logic [2:0] led;
    logic       busy;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int blanked;
    logic [2:0] rm;
    int rt;

    vecs[0]  = '{M_RUN,   23, 7, 8'h5B, 8'h4F, 3'b010, 1'b0};
    vecs[1]  = '{M_CLEAR, 23, 1, 8'h5B, 8'h4F, 3'b100, 1'b0};
    vecs[2]  = '{M_IDLE,  23, 1, 8'h5B, 8'h4F, 3'b001, 1'b0};
    vecs[3]  = '{3'b111,  23, 1, 8'h00, 8'h00, 3'b000, 1'b0};
    vecs[4]  = '{M_RUN,    5, 1, 8'h5B, 8'h4F, 3'b010, 1'b1};
    vecs[5]  = '{M_RUN,    5, 6, 8'h00, 8'h6D, 3'b010, 1'b0};
    vecs[6]  = '{M_RUN,    0, 7, 8'h00, 8'h3F, 3'b010, 1'b0};
    vecs[7]  = '{M_RUN,   31, 7, 8'h4F, 8'h06, 3'b010, 1'b0};
    vecs[8]  = '{M_RUN,    9, 7, 8'h00, 8'h6F, 3'b010, 1'b0};
    vecs[9]  = '{M_RUN,   10, 7, 8'h06, 8'h3F, 3'b010, 1'b0};
    vecs[10] = '{M_CLEAR, 19, 7, 8'h06, 8'h6F, 3'b100, 1'b0};
    vecs[11] = '{3'b000,  19, 1, 8'h00, 8'h00, 3'b000, 1'b0};
    vecs[12] = '{M_RUN,   19, 1, 8'h06, 8'h6F, 3'b010, 1'b0};

    applyStimulus(M_RUN, 0, 1'b0);
    tick();
    tick();
    checkOutput("reset", 8'h00, 8'h3F, 3'b000, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].mode, vecs[i].t, 1'b1);
      repeat (vecs[i].cycles) tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].ss1, vecs[i].ss0, vecs[i].led, vecs[i].busy);
    end

    // IDLE with a stable value: blinks only when the macro is on.
    applyStimulus(M_IDLE, 12, 1'b1);
    blanked = 0;
    for (int i = 1; i <= 160; i++) begin
      tick();
      checkModel("idle_display");
      if (ss1_o == 8'h00 && ss0_o == 8'h00) blanked++;
    end
    checks++;
`ifdef STOPWATCH_DISPLAY_BLINK_EN
    if (blanked != 60) begin
      failures++;
      $display("[TB] FAIL blink_count: got %0d blank cycles, expected 60", blanked);
    end
`else
    if (blanked != 0) begin
      failures++;
      $display("[TB] FAIL steady_count: got %0d blank cycles, expected 0", blanked);
    end
`endif
    applyStimulus(M_RUN, 12, 1'b1);
    tick();
    checkOutput("idle_exit", 8'h06, 8'h5B, 3'b010, 1'b0);

    // Overlap: 31 in flight, then 9 arrives; only 12 -> 31 -> 9 may ever be shown.
    applyStimulus(M_RUN, 31, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) applyStimulus(M_RUN, 9, 1'b1);
      tick();
      if (i <= 6)       checkOutput($sformatf("overlap%0d", i), 8'h06, 8'h5B, 3'b010, 1'b1);
      else if (i == 7)  checkOutput($sformatf("overlap%0d", i), 8'h4F, 8'h06, 3'b010, 1'b0);
      else if (i <= 13) checkOutput($sformatf("overlap%0d", i), 8'h4F, 8'h06, 3'b010, 1'b1);
      else              checkOutput($sformatf("overlap%0d", i), 8'h00, 8'h6F, 3'b010, 1'b0);
    end

    // Reset landing on the third shift cycle of converting 17.
    applyStimulus(M_RUN, 17, 1'b1);
    repeat (3) tick();
    applyStimulus(M_RUN, 17, 1'b0);
    tick();
    checkOutput("reset_mid", 8'h00, 8'h3F, 3'b000, 1'b0);
    applyStimulus(M_RUN, 17, 1'b1);
    repeat (6) tick();
    checkOutput("reset_mid_busy", 8'h00, 8'h3F, 3'b010, 1'b1);
    tick();
    checkOutput("reset_mid_done", 8'h06, 8'h07, 3'b010, 1'b0);

    rm = M_RUN;
    rt = 17;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0, 1: rm = M_RUN;
          2:    rm = M_CLEAR;
`ifdef STOPWATCH_DISPLAY_BLINK_EN
          3:    rm = M_RUN;
`else
          3:    rm = M_IDLE;
`endif
          4:    rm = 3'b111;
          default: rm = 3'($urandom_range(0, 7));
        endcase
      end
`ifdef STOPWATCH_DISPLAY_BLINK_EN
      if (rm == M_IDLE) rm = M_CLEAR;
`endif
      if ($urandom_range(0, 5) == 0) rt = int'($urandom_range(0, 31));
      applyStimulus(rm, rt, ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
      tick();
      checkModel("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
